// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetcher with a DEPTH-entry queue; FETCH_UNIT_PERF_EN adds perf counters
module fetch_unit #(
  parameter int ADDR_W = 64,
  parameter int INST_W = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc
`ifdef FETCH_UNIT_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_flushes
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  typedef enum logic {IDLE, WAIT} state_e;
  state_e state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, req_pc_q, req_pc_d;
  logic stale_q, stale_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PW:0] cnt_q, cnt_d;
  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem [DEPTH];
  logic issue, resp, push, pop;
  // Issue/accept/pop decisions and next-state; a redirect overrides everything else
  always_comb begin
    issue = reset && state_q == IDLE && cnt_q != FULL && !br_taken;
    resp = state_q == WAIT && imem_rvalid;
    push = resp && !stale_q && !br_taken;
    pop = inst_valid && inst_ready && !br_taken;
    state_d = issue ? WAIT : resp ? IDLE : state_q;
    stale_d = resp ? 1'b0 : (state_q == WAIT && br_taken) ? 1'b1 : stale_q;
    pc_d = br_taken ? br_target : issue ? pc_q + ADDR_W'(4) : pc_q;
    req_pc_d = issue ? pc_q : req_pc_q;
    head_d = br_taken ? '0 : head_q + PW'(pop);
    tail_d = br_taken ? '0 : tail_q + PW'(push);
    cnt_d = br_taken ? '0 : cnt_q + (PW+1)'(push) - (PW+1)'(pop);
  end
  // Control state with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
      req_pc_q <= '0;
      stale_q <= 1'b0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      req_pc_q <= req_pc_d;
      stale_q <= stale_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q <= cnt_d;
    end
  end
  // Queue storage; contents are only observable through a valid head, so no reset needed
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[tail_q] <= imem_rdata;
      pc_mem[tail_q] <= req_pc_q;
    end
  end
  assign imem_req = issue;
  assign imem_addr = pc_q;
  assign inst_valid = cnt_q != '0;
  assign inst = inst_valid ? inst_mem[head_q] : '0;
  assign inst_pc = inst_valid ? pc_mem[head_q] : '0;
`ifdef FETCH_UNIT_PERF_EN
  logic [31:0] fetched_q, flushes_q;
  // Pop and redirect counters, wrapping naturally at 2^32
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetched_q <= '0;
      flushes_q <= '0;
    end else begin
      fetched_q <= fetched_q + 32'(pop);
      flushes_q <= flushes_q + 32'(br_taken);
    end
  end
  assign perf_fetched = fetched_q;
  assign perf_flushes = flushes_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit (plus an 8-bit address instance for PC wrap)
module tb_fetch_unit;
  localparam int AW = 64;
  localparam int IW = 32;
  localparam int DEPTH = 4;
  logic clk = 0;
  logic reset = 0;
  always #5 clk = ~clk;
  logic imem_req, inst_valid;
  logic [AW-1:0] imem_addr, inst_pc;
  logic [IW-1:0] inst;
  logic imem_rvalid = 0, br_taken = 0, inst_ready = 0;
  logic [IW-1:0] imem_rdata = '0;
  logic [AW-1:0] br_target = '0;
`ifdef FETCH_UNIT_PERF_EN
  logic [31:0] perf_fetched, perf_flushes;
`endif
  logic req2, valid2;
  logic [7:0] addr2, pc2;
  logic [IW-1:0] inst2;
  logic rvalid2 = 0, br2 = 0, ready2 = 1;
  logic [IW-1:0] rdata2 = '0;
  logic [7:0] tgt2 = '0;

  fetch_unit #(.ADDR_W(AW), .INST_W(IW), .DEPTH(DEPTH), .RESET_PC('0)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .br_taken(br_taken),
    .br_target(br_target), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc)
`ifdef FETCH_UNIT_PERF_EN
    , .perf_fetched(perf_fetched), .perf_flushes(perf_flushes)
`endif
  );

  fetch_unit #(.ADDR_W(8), .INST_W(IW), .DEPTH(DEPTH), .RESET_PC(8'hFC)) dut8 (
    .clk(clk), .reset(reset), .imem_req(req2), .imem_addr(addr2),
    .imem_rvalid(rvalid2), .imem_rdata(rdata2), .br_taken(br2),
    .br_target(tgt2), .inst_valid(valid2), .inst_ready(ready2),
    .inst(inst2), .inst_pc(pc2)
`ifdef FETCH_UNIT_PERF_EN
    , .perf_fetched(), .perf_flushes()
`endif
  );

  typedef struct { logic [AW-1:0] pc; logic [IW-1:0] d; } ent_t;
  ent_t sb[$];
  logic [AW-1:0] pc_log[$];
  logic [AW-1:0] req_log[$];
  logic [7:0] a2_log[$];
  int checks = 0, errs = 0, cyc = 0, req_cnt = 0, pop_cnt = 0;
  int first_req = -1, first_valid = -1, resp_delay = 1, pend_cnt = 0;
  bit rdy = 0, br = 0, stray = 0, pend = 0, pend_stale = 0, r2_pend = 0;
  logic [AW-1:0] tgt = '0, pend_addr = '0, exp_pc = '0;

  function automatic logic [IW-1:0] data_of(input logic [AW-1:0] a);
    return (a[31:0] * 32'd7) ^ 32'hC0DE_0000;
  endfunction

  task automatic tick();
    bit exp_req, deliver;
    int occ;
    ent_t e;
    deliver = pend && pend_cnt == 0;
    imem_rvalid = deliver || stray;
    imem_rdata = deliver ? data_of(pend_addr) : 32'hDEAD_BEEF;
    br_taken = br;
    br_target = tgt;
    inst_ready = rdy;
    rvalid2 = r2_pend;
    #1;
    occ = sb.size();
    exp_req = !pend && occ < DEPTH && !br;
    checks++;
    if (imem_req !== exp_req) begin
      errs++;
      $display("FAIL imem_req cyc %0d: got %b expected %b", cyc, imem_req, exp_req);
    end
    checks++;
    if (inst_valid !== (occ != 0)) begin
      errs++;
      $display("FAIL inst_valid cyc %0d: got %b expected %b", cyc, inst_valid, occ != 0);
    end
    if (first_valid < 0 && inst_valid === 1'b1) first_valid = cyc;
    if (occ != 0 && rdy && !br) begin
      e = sb.pop_front();
      pc_log.push_back(e.pc);
      pop_cnt++;
      checks++;
      if (inst !== e.d || inst_pc !== e.pc) begin
        errs++;
        $display("FAIL pop cyc %0d: got pc %h inst %h expected pc %h inst %h", cyc, inst_pc, inst, e.pc, e.d);
      end
    end
    if (deliver) begin
      pend = 0;
      if (!pend_stale && !br) sb.push_back('{pc: pend_addr, d: data_of(pend_addr)});
    end else if (pend) pend_cnt--;
    if (br) begin
      sb.delete();
      if (pend) pend_stale = 1;
      exp_pc = tgt;
    end
    if (imem_req === 1'b1) req_log.push_back(imem_addr);
    if (exp_req) begin
      checks++;
      if (imem_addr !== exp_pc) begin
        errs++;
        $display("FAIL imem_addr cyc %0d: got %h expected %h", cyc, imem_addr, exp_pc);
      end
      if (first_req < 0) first_req = cyc;
      req_cnt++;
      pend = 1;
      pend_stale = 0;
      pend_addr = exp_pc;
      pend_cnt = resp_delay - 1;
      exp_pc = exp_pc + 4;
    end
    if (req2 === 1'b1) a2_log.push_back(addr2);
    r2_pend = req2 === 1'b1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 0;
    imem_rvalid = 1;
    rvalid2 = 1;
    #1;
    checks++;
    if (imem_req !== 1'b0 || inst_valid !== 1'b0 || inst !== '0 || inst_pc !== '0 || req2 !== 1'b0) begin
      errs++;
      $display("FAIL reset_outputs: got req %b valid %b inst %h pc %h req2 %b expected 0 0 0 0 0", imem_req, inst_valid, inst, inst_pc, req2);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    imem_rvalid = 0;
    rvalid2 = 0;
    reset = 1;
    sb.delete(); pc_log.delete(); req_log.delete(); a2_log.delete();
    pend = 0; pend_stale = 0; r2_pend = 0; stray = 0; br = 0;
    exp_pc = '0; cyc = 0; req_cnt = 0; pop_cnt = 0; first_req = -1; first_valid = -1;
  endtask

  task automatic test_reset();
    do_reset();
    rdy = 0;
    resp_delay = 3;
    tick();
    do_reset();
    resp_delay = 1;
    repeat (3) tick();
    checks++;
    if (req_log.size() < 1 || req_log[0] !== '0 || first_req != 0) begin
      errs++;
      $display("FAIL reset_first_req: got %0d reqs first_req cyc %0d expected addr 0 at cyc 0", req_log.size(), first_req);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    rdy = 1;
    resp_delay = 1;
    repeat (12) tick();
    checks++;
    if (first_valid - first_req != 2) begin
      errs++;
      $display("FAIL latency: got %0d cycles expected 2", first_valid - first_req);
    end
    checks++;
    if (pc_log.size() < 4 || pc_log[0] !== 64'h0 || pc_log[1] !== 64'h4 || pc_log[2] !== 64'h8 || pc_log[3] !== 64'hC) begin
      errs++;
      $display("FAIL pc_sequence: got %0d pops expected pcs 0,4,8,c", pc_log.size());
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    rdy = 0;
    resp_delay = 1;
    for (int i = 0; i < 20; i++) begin
      stray = i == 15;
      tick();
    end
    stray = 0;
    checks++;
    if (req_cnt != 4 || imem_req !== 1'b0) begin
      errs++;
      $display("FAIL full_queue: got %0d reqs req %b expected 4 reqs req 0", req_cnt, imem_req);
    end
    rdy = 1;
    repeat (4) tick();
    checks++;
    if (pop_cnt != 4 || pc_log[0] !== 64'h0 || pc_log[1] !== 64'h4 || pc_log[2] !== 64'h8 || pc_log[3] !== 64'hC) begin
      errs++;
      $display("FAIL drain_order: got %0d pops expected 4 pops 0,4,8,c", pop_cnt);
    end
    repeat (4) tick();
    checks++;
    if (req_cnt <= 4) begin
      errs++;
      $display("FAIL resume: got %0d reqs expected more than 4", req_cnt);
    end
  endtask

  task automatic test_branch_wait();
    int n;
    do_reset();
    rdy = 0;
    resp_delay = 1;
    repeat (4) tick();
    resp_delay = 3;
    tick();
    br = 1;
    tgt = 64'h100;
    tick();
    br = 0;
    checks++;
    if (inst_valid !== 1'b0) begin
      errs++;
      $display("FAIL flush: got inst_valid %b expected 0", inst_valid);
    end
    n = req_log.size();
    pc_log.delete();
    rdy = 1;
    resp_delay = 1;
    repeat (8) tick();
    checks++;
    if (req_log.size() <= n || req_log[n] !== 64'h100) begin
      errs++;
      $display("FAIL redirect_addr: got %0d reqs after branch expected first at 100", req_log.size() - n);
    end
    checks++;
    if (pc_log.size() < 1 || pc_log[0] !== 64'h100) begin
      errs++;
      $display("FAIL redirect_pc: got %0d pops expected first pc 100", pc_log.size());
    end
  endtask

  task automatic test_branch_collide();
    int n;
    do_reset();
    rdy = 0;
    resp_delay = 1;
    tick();
    br = 1;
    tgt = 64'h200;
    tick();
    br = 0;
    checks++;
    if (inst_valid !== 1'b0) begin
      errs++;
      $display("FAIL collide_write: got inst_valid %b expected 0", inst_valid);
    end
    n = req_log.size();
    pc_log.delete();
    rdy = 1;
    repeat (4) tick();
    checks++;
    if (req_log.size() <= n || req_log[n] !== 64'h200 || pc_log.size() < 1 || pc_log[0] !== 64'h200) begin
      errs++;
      $display("FAIL collide_redirect: got %0d reqs %0d pops expected first addr and pc 200", req_log.size() - n, pc_log.size());
    end
  endtask

  task automatic test_addr_wrap();
    do_reset();
    rdy = 1;
    repeat (8) tick();
    checks++;
    if (a2_log.size() < 3 || a2_log[0] !== 8'hFC || a2_log[1] !== 8'h00 || a2_log[2] !== 8'h04) begin
      errs++;
      $display("FAIL addr_wrap: got %0d reqs expected fc,00,04", a2_log.size());
    end
  endtask

`ifdef FETCH_UNIT_PERF_EN
  task automatic test_perf();
    do_reset();
    rdy = 1;
    resp_delay = 1;
    for (int i = 0; i < 100 && pop_cnt < 10; i++) tick();
    rdy = 0;
    tgt = 64'h300;
    br = 1;
    repeat (2) tick();
    br = 0;
    checks++;
    if (perf_fetched !== 32'd10 || perf_flushes !== 32'd2) begin
      errs++;
      $display("FAIL perf_counts: got %0d %0d expected 10 2", perf_fetched, perf_flushes);
    end
    do_reset();
    checks++;
    if (perf_fetched !== 32'd0 || perf_flushes !== 32'd0) begin
      errs++;
      $display("FAIL perf_reset: got %0d %0d expected 0 0", perf_fetched, perf_flushes);
    end
  endtask
`endif

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_sequential();
    test_backpressure();
    test_branch_wait();
    test_branch_collide();
    test_addr_wrap();
`ifdef FETCH_UNIT_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end
endmodule
